// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory controller.
// Optional build macro DATA_MEM_PARITY_EN adds per-byte even parity.
package data_mem_pkg;
  typedef enum logic {INIT, RUN} state_t;

  localparam int BYTE_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int n_lanes(input int w);
    return w / BYTE_W;
  endfunction
endpackage

// File: rtl/data_mem_if.sv
// Request/response bus between the load-store stage (master) and the data memory (slave).
interface data_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  import data_mem_pkg::*;
  localparam int LANES = n_lanes(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LANES-1:0]  req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/data_mem_array.sv
// Storage array: one memory per byte lane, synchronous write, combinational read, no reset.
module data_mem_array #(
  parameter int LANES  = 2,
  parameter int LANE_W = 8,
  parameter int DEPTH  = 8,
  parameter int IW     = 3
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [LANES-1:0]             be,
  input  logic [IW-1:0]                addr,
  input  logic [LANES-1:0][LANE_W-1:0] wdata,
  output logic [LANES-1:0][LANE_W-1:0] rdata
);
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[g]) mem[addr] <= wdata[g];
    end

    assign rdata[g] = mem[addr];
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: zero-fill FSM, range check, registered 1-cycle response.
// DATA_MEM_PARITY_EN adds one even-parity bit per byte and the err_inject input.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DATA_MEM_PARITY_EN
  input  logic err_inject,
`endif
  data_mem_if.slave bus
);
  localparam int LANES = n_lanes(DATA_W);
  localparam int IW    = clog2(DEPTH);
`ifdef DATA_MEM_PARITY_EN
  localparam int LANE_W = BYTE_W + 1;
`else
  localparam int LANE_W = BYTE_W;
`endif

  state_t                      state;
  logic [IW-1:0]               cnt;
  logic                        ready_q, done_q, vld_q, err_q;
  logic [DATA_W-1:0]           rdata_q;
  logic                        accept, in_range, arr_we, par_err;
  logic [LANES-1:0]            arr_be;
  logic [IW-1:0]               arr_addr;
  logic [LANES-1:0][LANE_W-1:0] wlane, rlane;
  logic [DATA_W-1:0]           rword;

  assign accept   = bus.req_valid && ready_q;
  // Full-width compare so high address bits never alias onto a valid word.
  assign in_range = bus.req_addr < ADDR_W'(DEPTH);

  always_comb begin
    arr_we   = 1'b0;
    arr_be   = '0;
    arr_addr = bus.req_addr[IW-1:0];
    wlane    = '0;
    rword    = '0;
    par_err  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      rword[i*BYTE_W +: BYTE_W] = rlane[i][BYTE_W-1:0];
`ifdef DATA_MEM_PARITY_EN
      par_err = par_err | (^rlane[i]);
`endif
    end
    if (state == INIT) begin
      // Sweep writes all-zero words; zero parity is correct even parity for zero data.
      arr_we   = 1'b1;
      arr_be   = '1;
      arr_addr = cnt;
    end else begin
      arr_we = accept && bus.req_we && in_range;
      arr_be = bus.req_be;
      for (int i = 0; i < LANES; i++) begin
        wlane[i][BYTE_W-1:0] = bus.req_wdata[i*BYTE_W +: BYTE_W];
`ifdef DATA_MEM_PARITY_EN
        wlane[i][BYTE_W] = (^bus.req_wdata[i*BYTE_W +: BYTE_W]) ^ err_inject;
`endif
      end
    end
  end

  data_mem_array #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (wlane),
    .rdata (rlane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      vld_q   <= accept;
      err_q   <= accept && (!in_range || (!bus.req_we && par_err));
      rdata_q <= (accept && !bus.req_we && in_range) ? rword : '0;
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IW'(DEPTH - 1)) begin
            state   <= RUN;
            cnt     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        RUN:     ;
        default: state <= INIT;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.init_done = done_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;
endmodule
